// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for seg_scan_ctrl -- active-low hex segment codes (bit 0 = a .. bit 6 = g), SEG_OFF, ANO_OFF, DIGITS
package seg_pkg;
  localparam int DIGITS = 4;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] ANO_OFF = 4'b1111;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
  localparam logic [15:0][6:0] SEG_HEX = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                          SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
endpackage

// File: rtl/hex7_decode.sv
// hex7_decode: combinational hex nibble to active-low 7-segment code; ports hex[3:0] in, seg[6:0] out (bit 0 = a)
module hex7_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_HEX[hex];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed 7-seg scanner; ports clk, reset, en, ld, value[15:0] in; leds[6:0], ano[3:0], frame_done out; LEADING_ZERO_BLANK_EN darkens leading zero digits
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        ld,
  input  logic [15:0] value,
  output logic [6:0]  leds,
  output logic [3:0]  ano,
  output logic        frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYC);
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [15:0] shadow, display, next_disp;
  logic [6:0] seg;
  logic blank, wrap, dark, last_slot;
  hex7_decode u_dec (.hex(display[{idx, 2'b00} +: 4]), .seg(seg));
  assign blank = cnt < BLANK;
  assign wrap = cnt == LAST;
  assign last_slot = idx == 2'(DIGITS - 1);
  assign next_disp = ld ? value : shadow;
`ifdef LEADING_ZERO_BLANK_EN
  assign dark = (idx != 2'd0) && ((display >> {idx, 2'b00}) == 16'd0);
`else
  assign dark = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      shadow <= '0;
      display <= '0;
      ano <= ANO_OFF;
      leds <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      shadow <= next_disp;
      if (!en) begin
        cnt <= '0;
        idx <= '0;
        display <= next_disp;
        ano <= ANO_OFF;
        leds <= SEG_OFF;
        frame_done <= 1'b0;
      end else begin
        cnt <= wrap ? '0 : cnt + 1'b1;
        idx <= idx + {1'b0, wrap};
        if (wrap && last_slot) display <= next_disp;
        ano <= (blank || dark) ? ANO_OFF : ~(4'b0001 << idx);
        leds <= blank ? SEG_OFF : seg;
        frame_done <= wrap && last_slot;
      end
    end
  end
endmodule
